// File: rtl/aud_recorder.sv
// aud_recorder: I2S left-channel capture, one SRAM write strobe per 16-bit sample.
// Optional peak-magnitude tracking (o_peak) is compiled in with `define AUD_REC_PEAK_EN.

module aud_recorder #(
  parameter int unsigned         P_ADDR_W   = 20,
  parameter logic [P_ADDR_W-1:0] P_MAX_ADDR = 20'hFFFFF
) (
  input  logic                i_bclk,
  input  logic                i_rst_n,
  input  logic                i_adclrck,
  input  logic                i_adcdat,
  input  logic                i_start,
  input  logic                i_pause,
  input  logic                i_stop,
  output logic [15:0]         o_data,
  output logic                o_we,
  output logic [P_ADDR_W-1:0] o_address,
  output logic                o_full,
  output logic                o_busy
`ifdef AUD_REC_PEAK_EN
  ,
  output logic [14:0]         o_peak
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_FALL,
    S_REC,
    S_WRITE,
    S_PAUSED
  } state_e;

  state_e                state_q, state_d;
  logic                  lrc_q;
  logic [3:0]            cnt_q, cnt_d;
  logic [14:0]           shift_q, shift_d;
  logic [15:0]           data_q, data_d;
  logic                  we_q, we_d;
  logic [P_ADDR_W-1:0]   addr_q, addr_d;
  logic                  full_q, full_d;
  logic                  pause_q, pause_d;

  logic frame_start;
  logic at_max;

  // The bit sampled on the frame-start edge is the I2S delay bit; capture begins on the next edge.
  assign frame_start = lrc_q & ~i_adclrck;
  assign at_max      = (addr_q == P_MAX_ADDR);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    // NOTE: default assignment first so no path through the block infers a latch.
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (i_start) state_d = S_WAIT_FALL;
      S_WAIT_FALL: begin
        if (i_stop)           state_d = S_IDLE;
        else if (i_pause)     state_d = S_PAUSED;
        else if (frame_start) state_d = S_REC;
      end
      S_REC: begin
        if (i_stop)             state_d = S_IDLE;
        else if (cnt_q == 4'd15) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (i_stop || at_max)        state_d = S_IDLE;
        else if (pause_q || i_pause) state_d = S_PAUSED;
        else                         state_d = S_WAIT_FALL;
      end
      S_PAUSED: begin
        if (i_stop)                 state_d = S_IDLE;
        else if (!i_pause && i_start) state_d = S_WAIT_FALL;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_busy = (state_q == S_WAIT_FALL) || (state_q == S_REC) || (state_q == S_WRITE);

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    full_d  = full_q;
    pause_d = pause_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          addr_d = '0;
          full_d = 1'b0;
        end
      end
      S_WAIT_FALL: if (frame_start) cnt_d = 4'd0;
      S_REC: begin
        if (!i_stop) begin
          shift_d = {shift_q[13:0], i_adcdat};
          cnt_d   = cnt_q + 4'd1;
          if (i_pause) pause_d = 1'b1;
          if (cnt_q == 4'd15) begin
            data_d = {shift_q, i_adcdat};
            we_d   = 1'b1;
          end
        end
      end
      // The strobed word always counts, even when a stop arrives on this edge.
      S_WRITE: begin
        if (at_max) full_d = 1'b1;
        else        addr_d = addr_q + P_ADDR_W'(1);
      end
      default: ;
    endcase
    if (state_d != S_REC && state_d != S_WRITE) pause_d = 1'b0;
  end

  always_ff @(posedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lrc_q   <= 1'b1;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      full_q  <= 1'b0;
      pause_q <= 1'b0;
    end else begin
      lrc_q   <= i_adclrck;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      full_q  <= full_d;
      pause_q <= pause_d;
    end
  end

  assign o_data    = data_q;
  assign o_we      = we_q;
  assign o_address = addr_q;
  assign o_full    = full_q;

`ifdef AUD_REC_PEAK_EN
  logic [14:0] peak_q, peak_d;
  logic [15:0] mag;
  logic [14:0] mag_sat;

  // -32768 has no positive 16-bit twin; it saturates to 32767.
  always_comb begin
    mag     = data_q[15] ? (~data_q + 16'd1) : data_q;
    mag_sat = mag[15] ? 15'h7FFF : mag[14:0];
    peak_d  = peak_q;
    if (state_q == S_IDLE && i_start)                 peak_d = '0;
    else if (state_q == S_WRITE && mag_sat > peak_q) peak_d = mag_sat;
  end

  always_ff @(posedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) peak_q <= '0;
    else          peak_q <= peak_d;
  end

  assign o_peak = peak_q;
`endif

endmodule
